// File: rtl/hm2_port_mux_if.sv
// rtl/hm2_port_mux_if.sv - host register bus bundle for hm2_port_mux
//
// Purpose: groups the HostMot2 register bus and the busy flag of the port mux.
// Signals:
//   reg_sel  0 = MODE, 1 = STATUS
//   wr, rd   write / read strobes sampled on clkmed
//   wdata    write data
//   rdata    registered read data
//   busy     high while a mode change is in progress
// Modports: master = bus host, slave = hm2_port_mux.
interface hm2_port_mux_if #(
  parameter int BusWidth = 32
) ();
  logic                reg_sel;
  logic                wr;
  logic                rd;
  logic [BusWidth-1:0] wdata;
  logic [BusWidth-1:0] rdata;
  logic                busy;

  modport master (output reg_sel, output wr, output rd, output wdata,
                  input rdata, input busy);
  modport slave  (input reg_sel, input wr, input rd, input wdata,
                  output rdata, output busy);
endinterface

// File: rtl/hm2_port_mux.sv
// rtl/hm2_port_mux.sv - runtime per-port I/O mux between HostMot2 core and GPIO headers
//
// Purpose: maps core pin i to header pin i, masked per port by a 2-bit mode
// (0 straight, 1 DB25, 2/3 disabled). Mode changes drain the affected ports
// (oe/out/in forced low) for GuardCycles clocks before the new mode applies.
// Ports:
//   clkmed, reset      clock, synchronous active-high reset
//   bus                register bus (MODE / STATUS) plus busy flag
//   hm2_out, hm2_oe    core output data / enables
//   hm2_in             synchronized, masked header inputs to the core
//   gpio_out, gpio_oe  registered header output data / enables
//   gpio_in            raw header inputs
module hm2_port_mux #(
  parameter int IOPorts     = 3,
  parameter int PortWidth   = 24,
  parameter int IOWidth     = IOPorts * PortWidth,
  parameter int NumGPIO     = 2,
  parameter int GPIOWidth   = 36,
  parameter int DB25Width   = 17,
  parameter int GuardCycles = 16,
  parameter int BusWidth    = 32,
  parameter int DefaultMode = 0
) (
  input  logic                         clkmed,
  input  logic                         reset,
  hm2_port_mux_if.slave                bus,
  input  logic [IOWidth-1:0]           hm2_out,
  input  logic [IOWidth-1:0]           hm2_oe,
  output logic [IOWidth-1:0]           hm2_in,
  output logic [NumGPIO*GPIOWidth-1:0] gpio_out,
  output logic [NumGPIO*GPIOWidth-1:0] gpio_oe,
  input  logic [NumGPIO*GPIOWidth-1:0] gpio_in
);

  localparam int MW = 2 * IOPorts;
  localparam int HW = NumGPIO * GPIOWidth;
  localparam int CW = $clog2(GuardCycles + 1);
  localparam logic [MW-1:0] RESET_MODE = {IOPorts{2'(DefaultMode)}};
  localparam logic [CW-1:0] GUARD_LOAD = CW'(GuardCycles - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, APPLY} state_t;

  state_t              state, state_n;
  logic [MW-1:0]       active_mode, active_n;
  logic [MW-1:0]       pending_mode, pending_n;
  logic [IOPorts-1:0]  drain_mask, drain_n;
  logic [CW-1:0]       guard_cnt, guard_n;
  logic                busy_q;
  logic [BusWidth-1:0] rdata_q, rdata_d;

  logic                mode_wr;
  logic [MW-1:0]       wr_mode;
  logic [MW-1:0]       pend_upd;
  logic [IOPorts-1:0]  diff_wr, diff_apply;
  logic [IOWidth-1:0]  en_n, en_q;
  logic [IOWidth-1:0]  sync1, sync2;

  assign mode_wr  = bus.wr && !bus.reg_sel;
  assign wr_mode  = bus.wdata[MW-1:0];
  // pending_mode as it will stand after an APPLY-cycle write
  assign pend_upd = mode_wr ? wr_mode : pending_mode;

  generate
    for (genvar p = 0; p < IOPorts; p++) begin : g_diff
      assign diff_wr[p]    = wr_mode[2*p +: 2] != active_mode[2*p +: 2];
      assign diff_apply[p] = pend_upd[2*p +: 2] != pending_mode[2*p +: 2];
    end

    // Outputs are registered from next-state mode/mask so a drain takes
    // effect on the same edge that samples the write.
    for (genvar i = 0; i < IOWidth; i++) begin : g_pin
      localparam int  P    = i / PortWidth;
      localparam bit  LOW  = (i % PortWidth) < DB25Width;
      assign en_n[i] = !drain_n[P] &&
                       (active_n[2*P +: 2] == 2'd0 || (active_n[2*P +: 2] == 2'd1 && LOW));
      assign en_q[i] = !drain_mask[P] &&
                       (active_mode[2*P +: 2] == 2'd0 || (active_mode[2*P +: 2] == 2'd1 && LOW));
    end

    if (BusWidth > MW) begin : g_unused_wdata
      logic unused_wdata;
      assign unused_wdata = ^bus.wdata[BusWidth-1:MW];
    end
    if (HW > IOWidth) begin : g_unused_gpio
      logic unused_gpio_in;
      assign unused_gpio_in = ^gpio_in[HW-1:IOWidth];
    end
  endgenerate

  always_comb begin
    state_n   = state;
    active_n  = active_mode;
    pending_n = pending_mode;
    drain_n   = drain_mask;
    guard_n   = guard_cnt;
    case (state)
      IDLE: begin
        if (mode_wr) begin
          pending_n = wr_mode;
          if (wr_mode != active_mode) begin
            drain_n = diff_wr;
            guard_n = GUARD_LOAD;
            state_n = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (mode_wr) begin
          pending_n = wr_mode;
          drain_n   = drain_mask | diff_wr;
          guard_n   = GUARD_LOAD;
        end else if (guard_cnt == '0) begin
          state_n = APPLY;
        end else begin
          guard_n = guard_cnt - CW'(1);
        end
      end
      APPLY: begin
        active_n  = pending_mode;
        pending_n = pend_upd;
        if (pend_upd != pending_mode) begin
          drain_n = diff_apply;
          guard_n = GUARD_LOAD;
          state_n = DRAIN;
        end else begin
          drain_n = '0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rdata_d = '0;
    if (bus.reg_sel) begin
      rdata_d[0]         = busy_q;
      rdata_d[IOPorts:1] = drain_mask;
    end else begin
      rdata_d[MW-1:0] = active_mode;
    end
  end

  always_ff @(posedge clkmed) begin
    if (reset) begin
      state        <= IDLE;
      active_mode  <= RESET_MODE;
      pending_mode <= RESET_MODE;
      drain_mask   <= '0;
      guard_cnt    <= '0;
      busy_q       <= 1'b0;
      rdata_q      <= '0;
      gpio_out     <= '0;
      gpio_oe      <= '0;
      sync1        <= '0;
      sync2        <= '0;
    end else begin
      state        <= state_n;
      active_mode  <= active_n;
      pending_mode <= pending_n;
      drain_mask   <= drain_n;
      guard_cnt    <= guard_n;
      busy_q       <= (state_n != IDLE);
      if (bus.rd) rdata_q <= rdata_d;
      gpio_out     <= HW'(hm2_out & en_n);
      gpio_oe      <= HW'(hm2_oe & en_n);
      sync1        <= gpio_in[IOWidth-1:0];
      sync2        <= sync1;
    end
  end

  assign hm2_in    = sync2 & en_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_hm2_port_mux.sv
// tb/tb_hm2_port_mux.sv - scoreboard testbench for hm2_port_mux
module tb_hm2_port_mux;
  localparam int IOP = 3;
  localparam int PW  = 24;
  localparam int IOW = IOP * PW;
  localparam int NG  = 2;
  localparam int GW  = 36;
  localparam int HW  = NG * GW;
  localparam int DB  = 17;
  localparam int G   = 16;
  localparam int BW  = 32;
  localparam int MW  = 2 * IOP;

  typedef struct {
    logic [HW-1:0]  out;
    logic [HW-1:0]  oe;
    logic [IOW-1:0] hin;
    logic [BW-1:0]  rdata;
    logic           busy;
  } exp_t;

  logic           clkmed = 1'b0;
  logic           reset;
  logic [IOW-1:0] hm2_out, hm2_oe, hm2_in;
  logic [HW-1:0]  gpio_out, gpio_oe, gpio_in;

  hm2_port_mux_if #(.BusWidth(BW)) bus ();

  hm2_port_mux #(
    .IOPorts(IOP), .PortWidth(PW), .IOWidth(IOW), .NumGPIO(NG), .GPIOWidth(GW),
    .DB25Width(DB), .GuardCycles(G), .BusWidth(BW), .DefaultMode(0)
  ) dut (
    .clkmed(clkmed), .reset(reset), .bus(bus),
    .hm2_out(hm2_out), .hm2_oe(hm2_oe), .hm2_in(hm2_in),
    .gpio_out(gpio_out), .gpio_oe(gpio_oe), .gpio_in(gpio_in)
  );

  always #5 clkmed = ~clkmed;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  // reference model state
  logic [MW-1:0]  m_act, m_pend;
  logic [IOP-1:0] m_mask;
  bit             m_busy;
  int             m_apply, m_edge;
  logic [IOW-1:0] m_s1, m_s2;
  logic [BW-1:0]  m_rdata;

  function automatic int code_of(input logic [MW-1:0] md, input int p);
    return int'((md >> (2 * p)) & MW'(3));
  endfunction

  function automatic logic [IOP-1:0] differ(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [IOP-1:0] d = '0;
    for (int p = 0; p < IOP; p++)
      if (code_of(a, p) != code_of(b, p)) d = d | (IOP'(1) << p);
    return d;
  endfunction

  function automatic bit pin_on(input logic [MW-1:0] md, input logic [IOP-1:0] mk, input int i);
    int p = i / PW;
    int c = code_of(md, p);
    if (((mk >> p) & IOP'(1)) != '0) return 1'b0;
    return (c == 0) || (c == 1 && (i % PW) < DB);
  endfunction

  task automatic chk(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // monitor: one expected entry per clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clkmed);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("gpio_out", gpio_out, e.out);
        chk("gpio_oe", gpio_oe, e.oe);
        chk("hm2_in", HW'(hm2_in), HW'(e.hin));
        chk("rdata", HW'(bus.rdata), HW'(e.rdata));
        chk("busy", HW'(bus.busy), HW'(e.busy));
      end
    end
  end

  // drive one cycle of stimulus and predict the state after the next edge
  task automatic step(input bit rst, input bit wr, input bit sel, input bit rd,
                      input logic [BW-1:0] wd);
    logic [95:0]    r96;
    logic [MW-1:0]  act_old, v;
    logic [IOP-1:0] mask_old;
    bit             busy_old, w, on;
    exp_t           x;
    @(negedge clkmed);
    #1;
    reset = rst; bus.wr = wr; bus.reg_sel = sel; bus.rd = rd; bus.wdata = wd;
    r96 = {$urandom, $urandom, $urandom}; hm2_out = r96[IOW-1:0];
    r96 = {$urandom, $urandom, $urandom}; hm2_oe  = r96[IOW-1:0];
    r96 = {$urandom, $urandom, $urandom}; gpio_in = r96[HW-1:0];

    act_old = m_act; mask_old = m_mask; busy_old = m_busy;
    if (rst) begin
      m_act = '0; m_pend = '0; m_mask = '0; m_busy = 0;
      m_s1 = '0; m_s2 = '0; m_rdata = '0;
    end else begin
      w = wr && !sel;
      v = wd[MW-1:0];
      if (rd) m_rdata = sel ? BW'({mask_old, busy_old}) : BW'(act_old);
      if (!m_busy) begin
        if (w) begin
          m_pend = v;
          if (v != m_act) begin
            m_mask = differ(v, m_act); m_busy = 1; m_apply = m_edge + G + 1;
          end
        end
      end else if (m_edge == m_apply) begin
        m_act = m_pend;
        if (w) m_pend = v;
        if (m_pend != m_act) begin
          m_mask = differ(m_pend, m_act); m_apply = m_edge + G + 1;
        end else begin
          m_mask = '0; m_busy = 0;
        end
      end else if (w) begin
        m_pend = v; m_mask = m_mask | differ(v, m_act); m_apply = m_edge + G + 1;
      end
      m_s2 = m_s1;
      m_s1 = gpio_in[IOW-1:0];
    end

    x.out = '0; x.oe = '0; x.hin = '0;
    for (int i = 0; i < IOW; i++) begin
      on = !rst && pin_on(m_act, m_mask, i);
      x.out[i] = on & hm2_out[i];
      x.oe[i]  = on & hm2_oe[i];
      x.hin[i] = on & m_s2[i];
    end
    x.rdata = m_rdata;
    x.busy  = m_busy;
    sb.push_back(x);
    m_edge++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, k[0], (k % 3) == 0, '0);
  endtask

  initial begin
    int r;
    logic [BW-1:0] wd;
    reset = 1'b1; bus.wr = 0; bus.rd = 0; bus.reg_sel = 0; bus.wdata = '0;
    hm2_out = '0; hm2_oe = '0; gpio_in = '0;
    m_act = '0; m_pend = '0; m_mask = '0; m_busy = 0; m_apply = 0; m_edge = 0;
    m_s1 = '0; m_s2 = '0; m_rdata = '0;

    for (int k = 0; k < 3; k++) step(1, 0, 0, 0, '0);
    idle(3);
    step(0, 1, 0, 0, 32'h01);          // port0 -> DB25
    idle(24);
    step(0, 1, 0, 1, 32'h01);          // port1 -> DB25... via 0x01 again? same value: no change
    idle(3);
    step(0, 1, 0, 0, 32'h01 ^ 32'h00); // equal to active: no drain
    step(0, 1, 0, 0, 32'h00);          // back to straight
    idle(4);
    step(0, 1, 0, 0, 32'h11);          // written during DRAIN: reload + widen mask
    idle(26);
    step(0, 1, 0, 0, 32'h0C);          // port1 disabled
    idle(22);
    step(0, 1, 0, 0, 32'h02);          // port0 disabled, then reset mid-drain
    idle(5);
    step(1, 0, 0, 0, '0);
    step(0, 0, 1, 1, '0);
    step(0, 0, 0, 1, '0);
    idle(3);

    for (int k = 0; k < 3000; k++) begin
      r = $urandom_range(0, 99);
      wd = $urandom;
      if (r < 4)      step(0, 1, ($urandom_range(0, 9) == 0), $urandom_range(0, 2) == 0, wd);
      else if (r < 6) step(0, 1, 0, 0, (wd & ~BW'(6'h3F)) | BW'(m_act));
      else if (r < 7) step(1, 0, 0, 0, wd);
      else            step(0, 0, wd[0], wd[1] & wd[2], wd);
    end
    idle(2);
    @(negedge clkmed);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
